// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
//   XLEN_DEF  default data width
//   REG_ZERO  architectural zero register (writes to it are never issued)
//   wr_req_t  write request {rd, data} at the default width
//   rd_match  true when a non-zero query register names a given rd
package rf_arb_pkg;

    localparam int         XLEN_DEF = 64;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] data;
    } wr_req_t;

    // x0 never carries a dependency, so a zero query never matches.
    function automatic logic rd_match(input logic [4:0] query, input logic [4:0] rd);
        return (query != REG_ZERO) && (query == rd);
    endfunction

endpackage

// File: rtl/rf_arb_skid_fifo.sv
// In-order skid buffer for MDU results that lost write-port arbitration.
//   clk, reset          clock, asynchronous active-low reset (empties the buffer)
//   push, push_rd/data  enqueue one entry (caller guarantees not full)
//   pop                 dequeue the head (caller guarantees not empty)
//   head_rd/head_data   oldest entry
//   full, empty         registered occupancy flags
//   entry_vld/entry_rd  per-slot valid and rd, for hazard comparison
module rf_arb_skid_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [4:0]            push_rd,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    output logic [4:0]            head_rd,
    output logic [XLEN-1:0]       head_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      entry_vld,
    output logic [DEPTH-1:0][4:0] entry_rd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                cnt_q;
    logic [DEPTH-1:0][4:0]        rd_mem;
    logic [DEPTH-1:0][XLEN-1:0]   data_mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            rd_mem   <= '0;
            data_mem <= '0;
        end else begin
            if (push) begin
                rd_mem[wr_ptr]   <= push_rd;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign entry_rd  = rd_mem;

    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy; DEPTH is a power of two so the wrap is free.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [AW-1:0] off;
        assign off          = AW'(i) - rd_ptr;
        assign entry_vld[i] = (CW'(off) < cnt_q);
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between write-back (WB) and the MDU.
// WB always wins; MDU results that lose are parked in-order in a skid buffer
// and drained on WB-idle cycles. Decode sees hazard_o for any parked rd, and
// pipe_stall_o requests a WB-idle bubble when parked results starve.
//   clk, reset                 clock, asynchronous active-low reset
//   wb_we_i/wb_rd_i/wb_data_i  write-back request
//   mdu_valid_i/rd/data, mdu_ready_o   MDU result handshake
//   query_rs1_i/query_rs2_i, hazard_o  decode RAW check (combinational)
//   pipe_stall_o               registered stall request
//   rf_we_o/rf_waddr_o/rf_wdata_o      registered register-file write port
// Build option RF_ARB_STATS_EN adds arb_collide_cnt_o and arb_stall_cnt_o,
// 32-bit saturating event counters.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int XLEN     = XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            mdu_valid_i,
    input  logic [4:0]      mdu_rd_i,
    input  logic [XLEN-1:0] mdu_data_i,
    output logic            mdu_ready_o,
    input  logic [4:0]      query_rs1_i,
    input  logic [4:0]      query_rs2_i,
    output logic            hazard_o,
    output logic            pipe_stall_o,
`ifdef RF_ARB_STATS_EN
    output logic [31:0]     arb_collide_cnt_o,
    output logic [31:0]     arb_stall_cnt_o,
`endif
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic                  wb_act, accept, mdu_live;
    logic                  pop, push, direct;
    logic                  full, empty;
    logic [4:0]            head_rd;
    logic [XLEN-1:0]       head_data;
    logic [DEPTH-1:0]      entry_vld;
    logic [DEPTH-1:0][4:0] entry_rd;
    logic [WW-1:0]         wait_q, wait_nxt;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign mdu_ready_o = ~full;
    assign wb_act      = wb_we_i && (wb_rd_i != REG_ZERO);
    assign accept      = mdu_valid_i && mdu_ready_o;
    assign mdu_live    = accept && (mdu_rd_i != REG_ZERO);

    assign pop    = !wb_act && !empty;
    assign direct = !wb_act && empty && mdu_live;
    assign push   = mdu_live && !direct;

    rf_arb_skid_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_rd   (mdu_rd_i),
        .push_data (mdu_data_i),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .entry_vld (entry_vld),
        .entry_rd  (entry_rd)
    );

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (rd_match(query_rs1_i, entry_rd[i]) ||
                                 rd_match(query_rs2_i, entry_rd[i])))
                hazard_o = 1'b1;
        end
        if (accept && (rd_match(query_rs1_i, mdu_rd_i) || rd_match(query_rs2_i, mdu_rd_i)))
            hazard_o = 1'b1;
    end

    // A non-empty buffer that does not pop this cycle is losing to WB.
    always_comb begin
        wait_nxt = wait_q;
        if (empty || pop)
            wait_nxt = '0;
        else if (wait_q != WW'(MAX_WAIT))
            wait_nxt = wait_q + WW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q       <= '0;
            pipe_stall_o <= 1'b0;
        end else begin
            wait_q <= wait_nxt;
            if (pop)
                pipe_stall_o <= 1'b0;
            else if (wait_nxt == WW'(MAX_WAIT))
                pipe_stall_o <= 1'b1;
        end
    end

    // Address/data hold their last value on idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_we_o <= wb_act || pop || direct;
            if (wb_act) begin
                rf_waddr_o <= wb_rd_i;
                rf_wdata_o <= wb_data_i;
            end else if (pop) begin
                rf_waddr_o <= head_rd;
                rf_wdata_o <= head_data;
            end else if (direct) begin
                rf_waddr_o <= mdu_rd_i;
                rf_wdata_o <= mdu_data_i;
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arb_collide_cnt_o <= '0;
            arb_stall_cnt_o   <= '0;
        end else begin
            if (wb_act && (!empty || push) && (arb_collide_cnt_o != '1))
                arb_collide_cnt_o <= arb_collide_cnt_o + 32'd1;
            if (pipe_stall_o && (arb_stall_cnt_o != '1))
                arb_stall_cnt_o <= arb_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a queue-based reference of the write port
// pushes the expected register-file write for every driven cycle; it is
// popped and compared after the next clock edge. Directed scenarios add
// fixed-value checks on top.
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int XLEN     = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_we_i;
    logic [4:0]      wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic            mdu_valid_i;
    logic [4:0]      mdu_rd_i;
    logic [XLEN-1:0] mdu_data_i;
    logic            mdu_ready_o;
    logic [4:0]      query_rs1_i;
    logic [4:0]      query_rs2_i;
    logic            hazard_o;
    logic            pipe_stall_o;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
`ifdef RF_ARB_STATS_EN
    logic [31:0]     collide_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_we_i      (wb_we_i),
        .wb_rd_i      (wb_rd_i),
        .wb_data_i    (wb_data_i),
        .mdu_valid_i  (mdu_valid_i),
        .mdu_rd_i     (mdu_rd_i),
        .mdu_data_i   (mdu_data_i),
        .mdu_ready_o  (mdu_ready_o),
        .query_rs1_i  (query_rs1_i),
        .query_rs2_i  (query_rs2_i),
        .hazard_o     (hazard_o),
        .pipe_stall_o (pipe_stall_o),
`ifdef RF_ARB_STATS_EN
        .arb_collide_cnt_o (collide_cnt),
        .arb_stall_cnt_o   (stall_cnt),
`endif
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o)
    );

    typedef struct {
        bit      we;
        wr_req_t w;
    } exp_t;

    exp_t          exp_q[$];
    wr_req_t       mq[$];
    int            m_wait;
    bit            m_stall;
    logic [4:0]    m_rd;
    logic [63:0]   m_data;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_wait  = 0;
        m_stall = 1'b0;
        m_rd    = '0;
        m_data  = '0;
    endtask

    task automatic idle_inputs();
        wb_we_i     = 1'b0;
        wb_rd_i     = '0;
        wb_data_i   = '0;
        mdu_valid_i = 1'b0;
        mdu_rd_i    = '0;
        mdu_data_i  = '0;
    endtask

    // Compare the registered write port against the oldest expectation.
    task automatic check_out();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we", rf_we_o, e.we);
            chk("rf_waddr", rf_waddr_o, e.w.rd);
            chk("rf_wdata", rf_wdata_o, e.w.data);
        end
        chk("stall", pipe_stall_o, m_stall);
    endtask

    function automatic bit q_hit(input logic [4:0] rd);
        return ((query_rs1_i != 0) && (query_rs1_i == rd)) ||
               ((query_rs2_i != 0) && (query_rs2_i == rd));
    endfunction

    // One clock cycle: check the previous cycle's result, drive, predict.
    task automatic step(input bit wwe, input logic [4:0] wrd, input logic [63:0] wd,
                        input bit mv, input logic [4:0] mrd, input logic [63:0] md);
        exp_t e;
        bit   wb_act, acc, pre_ne, popped, direct, hz;
        @(posedge clk);
        #1;
        check_out();
        wb_we_i = wwe; wb_rd_i = wrd; wb_data_i = wd;
        mdu_valid_i = mv; mdu_rd_i = mrd; mdu_data_i = md;
        #1;
        wb_act = wwe && (wrd != 0);
        pre_ne = (mq.size() > 0);
        acc    = mv && (mq.size() < DEPTH);
        chk("ready", mdu_ready_o, mq.size() < DEPTH);
        hz = 1'b0;
        foreach (mq[i]) if (q_hit(mq[i].rd)) hz = 1'b1;
        if (acc && q_hit(mrd)) hz = 1'b1;
        chk("hazard", hazard_o, hz);
        popped = 1'b0;
        direct = 1'b0;
        e.we   = 1'b1;
        if (wb_act) begin
            e.w.rd = wrd; e.w.data = wd;
        end else if (pre_ne) begin
            e.w = mq.pop_front();
            popped = 1'b1;
        end else if (acc && mrd != 0) begin
            e.w.rd = mrd; e.w.data = md;
            direct = 1'b1;
        end else begin
            e.we = 1'b0; e.w.rd = m_rd; e.w.data = m_data;
        end
        if (e.we) begin
            m_rd = e.w.rd; m_data = e.w.data;
        end
        if (acc && mrd != 0 && !direct) mq.push_back('{rd: mrd, data: md});
        if (!pre_ne || popped) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        if (popped) m_stall = 1'b0;
        else if (m_wait == MAX_WAIT) m_stall = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    // One-cycle asynchronous reset pulse in the middle of traffic.
    task automatic rst_pulse();
        @(posedge clk);
        #1;
        check_out();
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("rst_we", rf_we_o, 1'b0);
        chk("rst_waddr", rf_waddr_o, 5'd0);
        chk("rst_wdata", rf_wdata_o, 64'd0);
        chk("rst_stall", pipe_stall_o, 1'b0);
        chk("rst_ready", mdu_ready_o, 1'b1);
        chk("rst_hazard", hazard_o, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        query_rs1_i = '0;
        query_rs2_i = '0;
        reset = 1'b0;
        model_clear();
        #12;
        chk("init_we", rf_we_o, 1'b0);
        chk("init_waddr", rf_waddr_o, 5'd0);
        chk("init_wdata", rf_wdata_o, 64'd0);
        chk("init_stall", pipe_stall_o, 1'b0);
        chk("init_ready", mdu_ready_o, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Direct MDU write with WB idle.
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hA);
        chk("t1_ready", mdu_ready_o, 1'b1);
        idle();
        chk("t1_we", rf_we_o, 1'b1);
        chk("t1_waddr", rf_waddr_o, 5'd5);
        chk("t1_wdata", rf_wdata_o, 64'hA);

        // Collision: WB wins, x7 parks and raises a hazard until drained.
        query_rs1_i = 5'd7;
        step(1'b1, 5'd3, 64'h1, 1'b1, 5'd7, 64'h2);
        chk("t2_haz_accept", hazard_o, 1'b1);
        idle();
        chk("t2_waddr_wb", rf_waddr_o, 5'd3);
        chk("t2_wdata_wb", rf_wdata_o, 64'h1);
        chk("t2_haz_parked", hazard_o, 1'b1);
        idle();
        chk("t2_waddr_mdu", rf_waddr_o, 5'd7);
        chk("t2_wdata_mdu", rf_wdata_o, 64'h2);
        chk("t2_haz_clear", hazard_o, 1'b0);
        query_rs1_i = '0;

        // Full buffer: third result waits until the cycle after the first pop.
        step(1'b1, 5'd10, 64'h10, 1'b1, 5'd20, 64'h20);
        step(1'b1, 5'd11, 64'h11, 1'b1, 5'd21, 64'h21);
        step(1'b1, 5'd12, 64'h12, 1'b1, 5'd22, 64'h22);
        chk("t3_ready_full", mdu_ready_o, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd22, 64'h22);
        chk("t3_ready_popcyc", mdu_ready_o, 1'b0);
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd22, 64'h22);
        chk("t3_ready_after", mdu_ready_o, 1'b1);
        chk("t3_first", rf_waddr_o, 5'd20);
        idle();
        chk("t3_second", rf_waddr_o, 5'd21);
        idle();
        chk("t3_third", rf_waddr_o, 5'd22);
        idle();
        chk("t3_idle_we", rf_we_o, 1'b0);

        // Starvation: one parked entry, WB busy for MAX_WAIT cycles.
        step(1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 64'h99);
        step(1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'd0);
        step(1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 64'd0);
        step(1'b1, 5'd6, 64'h66, 1'b0, 5'd0, 64'd0);
        step(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0);
        chk("t4_stall_early", pipe_stall_o, 1'b0);
        step(1'b1, 5'd8, 64'h88, 1'b0, 5'd0, 64'd0);
        chk("t4_stall_on", pipe_stall_o, 1'b1);
        idle();
        chk("t4_stall_wb_wins", rf_waddr_o, 5'd8);
        chk("t4_stall_hold", pipe_stall_o, 1'b1);
        idle();
        chk("t4_drain_addr", rf_waddr_o, 5'd9);
        chk("t4_drain_data", rf_wdata_o, 64'h99);
        chk("t4_stall_off", pipe_stall_o, 1'b0);

        // x0: MDU rd=0 is dropped; WB rd=0 lets the parked entry drain.
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55);
        chk("t5_ready_x0", mdu_ready_o, 1'b1);
        idle();
        chk("t5_no_write", rf_we_o, 1'b0);
        step(1'b1, 5'd2, 64'h22, 1'b1, 5'd6, 64'h66);
        step(1'b1, 5'd0, 64'h77, 1'b0, 5'd0, 64'd0);
        idle();
        chk("t5_drain_addr", rf_waddr_o, 5'd6);
        chk("t5_drain_data", rf_wdata_o, 64'h66);

        // Reset with two parked entries: nothing from them is ever written.
        step(1'b1, 5'd1, 64'h1, 1'b1, 5'd14, 64'hE);
        step(1'b1, 5'd2, 64'h2, 1'b1, 5'd15, 64'hF);
        query_rs1_i = 5'd14;
        rst_pulse();
        idle();
        idle();
        idle();
        chk("t6_no_write", rf_we_o, 1'b0);
        query_rs1_i = '0;

        // Random traffic with alternating WB-heavy and WB-light phases.
        for (int i = 0; i < 400; i++) begin
            int   pwb;
            bit   wwe, mv;
            pwb = ((i / 40) % 2) ? 90 : 30;
            wwe = ($urandom_range(0, 99) < pwb);
            mv  = ($urandom_range(0, 99) < 45);
            query_rs1_i = 5'($urandom_range(0, 7));
            query_rs2_i = 5'($urandom_range(0, 7));
            step(wwe, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 mv, 5'($urandom_range(0, 7)), {$urandom, $urandom});
        end
        query_rs1_i = '0;
        query_rs2_i = '0;
        for (int i = 0; i < 6; i++) idle();
        @(posedge clk);
        #1;
        check_out();
        chk("final_empty_ready", mdu_ready_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single register-file write port between the pipeline write-back stage and the long-latency multiply/divide unit (MDU). WB always has priority. MDU results that lose arbitration are parked in a small in-order skid buffer and drained on idle write-port cycles. The block reports a read-after-write hazard to decode for any rd still parked, and requests a one-bubble pipeline stall when parked results starve.

Parameters:
DEPTH, 2, skid buffer entries (power of two, ≥2)
MAX_WAIT, 4, consecutive cycles a non-empty buffer may lose arbitration before pipe_stall_o is raised
XLEN, 64, data width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
wb_we_i  input  1  write-back stage write enable
wb_rd_i  input  5  write-back destination register
wb_data_i  input  XLEN  write-back data
mdu_valid_i  input  1  MDU result valid
mdu_rd_i  input  5  MDU destination register
mdu_data_i  input  XLEN  MDU result
mdu_ready_o  output  1  MDU result accepted this cycle when high with mdu_valid_i
query_rs1_i  input  5  decode source register 1
query_rs2_i  input  5  decode source register 2
hazard_o  output  1  a query register matches a pending MDU write
pipe_stall_o  output  1  freeze the MEM/WB boundary for one WB-idle cycle
rf_we_o  output  1  register-file write enable (registered)
rf_waddr_o  output  5  register-file write address (registered)
rf_wdata_o  output  XLEN  register-file write data (registered)

Behaviour:
- Reset (reset=0, asynchronous): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pipe_stall_o=0, buffer emptied, wait counter=0. Reset mid-operation discards every parked result; no partial write is issued.
- Writes to x0 are never issued. A WB write with rd=0 counts as WB idle. An accepted MDU result with rd=0 is consumed and dropped, not buffered.
- Per-cycle winner, in priority order: WB (wb_we_i && wb_rd_i≠0); then buffer head; then direct MDU (only when the buffer is empty and mdu_valid_i && mdu_ready_o).
- Latency: the winner's rd and data appear on rf_*_o at the next clk edge. If there is no winner, rf_we_o=0 the next cycle and rf_waddr_o/rf_wdata_o hold their previous values.
- mdu_ready_o is 1 exactly when the registered occupancy is below DEPTH. When the buffer is full, ready stays 0 even in a pop cycle, so there is no combinational path from ready to pop.
- Push rule: an accepted, non-x0 MDU result is pushed if it does not win directly (WB active, or buffer non-empty). A simultaneous push and pop is legal at any occupancy below DEPTH.
- Ordering: buffer is strict FIFO. MDU results are written in acceptance order and never bypass parked entries.
- Starvation: the wait counter increments each cycle the buffer is non-empty and WB wins. It clears on any pop or when the buffer is empty, and saturates at MAX_WAIT.
- When the counter reaches MAX_WAIT, pipe_stall_o is asserted (registered) on the next cycle. It stays high until the cycle after the next pop.
- If WB still asserts wb_we_i while pipe_stall_o=1, WB still wins; no data is lost.
- hazard_o is combinational. It is 1 if query_rs1_i or query_rs2_i is non-zero and equals the rd of any valid buffer entry, or the rd of an MDU result being accepted this cycle.
- WAW ordering between WB and parked MDU results to the same rd is prevented by decode through hazard_o. The arbiter does not reorder.

Optional Feature:
RF_ARB_STATS_EN:
- Defined: adds two 32-bit saturating output counters, reset to 0.
  - arb_collide_cnt_o increments on each cycle WB wins while the buffer is non-empty or an MDU result is pushed.
  - arb_stall_cnt_o increments on each cycle pipe_stall_o=1.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Decomposition:
- Shared package rf_arb_pkg holds:
  - XLEN_DEF=64
  - REG_ZERO=5'd0
  - the write-request struct type {rd[4:0], data[XLEN-1:0]}
- One sub-module, rf_arb_skid_fifo: DEPTH-entry FIFO with full/empty flags, head output, and a per-entry rd vector for hazard compare.
- Arbitration, starvation counter and output register stay in the top module.

Test Plan:
- Reset mid-operation: park 2 MDU entries, pulse reset low for 1 cycle → rf_we_o=0, buffer empty, mdu_ready_o=1 and no write from the parked entries appears afterward.
- WB idle, MDU valid rd=5 data=0xA → mdu_ready_o=1; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA.
- Collision, buffer drain:
  - WB rd=3 data=0x1 and MDU rd=7 data=0x2 in the same cycle → next cycle writes x3=0x1.
  - hazard_o=1 for query_rs1_i=7 while x7 is parked.
  - WB idle the following cycle → x7=0x2 written, then hazard_o=0.
- Full buffer: WB busy continuously while 3 MDU results are offered (DEPTH=2) → third sees mdu_ready_o=0 until the first pop, and the x-order of writes matches acceptance order.
- Starvation, MAX_WAIT=4: WB busy 4 cycles with 1 entry parked → pipe_stall_o=1 on cycle 5. After WB idles, the entry is written and pipe_stall_o drops on the following cycle.
- x0 handling:
  - MDU rd=0 → consumed with no rf write.
  - WB rd=0 concurrent with a parked entry → the parked entry is written that cycle.
